// File: rtl/chan_frame_rx.sv
// Receive-side deserializer for the channel-counter serial link.
// Rebuilds MSB-first words into an 8-slot bank with a registered read port.
module chan_frame_rx #(
    parameter int WIDTH = 16,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             sl_in,
    input  logic [2:0]       addr_in,
    input  logic             ovf_ch_in,
    input  logic [2:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_ovf,
    output logic             word_valid,
    output logic [2:0]       word_addr,
    output logic             frame_err,
    output logic [ERRW-1:0]  err_count
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             overrun;
    logic [2:0]       cur_addr;
    logic             cur_ovf;
    logic             commit;
    logic             discard;
    logic             hit;

    logic [WIDTH-1:0] bank    [8];
    logic             ovfbank [8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        discard   = 1'b0;
        unique case (state)
            IDLE: begin
                if (sl_in) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (!sl_in) begin
                    state_nxt = IDLE;
                    if (cnt == FULL && !overrun) commit  = 1'b1;
                    else                         discard = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            cnt      <= '0;
            overrun  <= 1'b0;
            cur_addr <= '0;
            cur_ovf  <= 1'b0;
        end else if (state == IDLE) begin
            if (sl_in) begin
                cur_addr <= addr_in;
                shreg    <= {{(WIDTH-1){1'b0}}, serial_in};
                cnt      <= CW'(1);
                overrun  <= 1'b0;
            end
        end else if (sl_in) begin
            // Bits beyond WIDTH are dropped; the frame is poisoned instead
            if (cnt != FULL) begin
                shreg <= {shreg[WIDTH-2:0], serial_in};
                cnt   <= cnt + CW'(1);
                if (cnt == FULL - CW'(1)) cur_ovf <= ovf_ch_in;
            end else begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                bank[i]    <= '0;
                ovfbank[i] <= 1'b0;
            end
        end else if (commit) begin
            bank[cur_addr]    <= shreg;
            ovfbank[cur_addr] <= cur_ovf;
        end
    end

    assign hit = commit && (cur_addr == rd_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data    <= '0;
            rd_ovf     <= 1'b0;
            word_valid <= 1'b0;
            word_addr  <= '0;
            frame_err  <= 1'b0;
            err_count  <= '0;
        end else begin
            rd_data    <= hit ? shreg   : bank[rd_addr];
            rd_ovf     <= hit ? cur_ovf : ovfbank[rd_addr];
            word_valid <= commit;
            frame_err  <= discard;
            if (commit) word_addr <= cur_addr;
            if (discard && err_count != '1) err_count <= err_count + ERRW'(1);
        end
    end

endmodule

// File: tb/tb_chan_frame_rx.sv
// Randomized scoreboard bench for chan_frame_rx.
// Frames are described abstractly; a reference bank predicts every outcome.
module tb_chan_frame_rx;

    localparam int WIDTH = 16;
    localparam int ERRW  = 8;
    localparam int ERRMAX = (1 << ERRW) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             serial_in = 1'b0;
    logic             sl_in = 1'b0;
    logic [2:0]       addr_in = '0;
    logic             ovf_ch_in = 1'b0;
    logic [2:0]       rd_addr = '0;
    logic [WIDTH-1:0] rd_data;
    logic             rd_ovf;
    logic             word_valid;
    logic [2:0]       word_addr;
    logic             frame_err;
    logic [ERRW-1:0]  err_count;

    chan_frame_rx #(.WIDTH(WIDTH), .ERRW(ERRW)) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .sl_in      (sl_in),
        .addr_in    (addr_in),
        .ovf_ch_in  (ovf_ch_in),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_ovf     (rd_ovf),
        .word_valid (word_valid),
        .word_addr  (word_addr),
        .frame_err  (frame_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       commit;
        bit [2:0] addr;
        int       errs;
    } ev_t;

    ev_t              expq[$];
    logic [WIDTH-1:0] mbank [8];
    bit               movf  [8];
    int               exp_errs;
    int               checks = 0;
    int               failures = 0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mbank[i] = '0;
            movf[i]  = 1'b0;
        end
        exp_errs = 0;
        expq.delete();
    endtask

    // A frame commits only if it has exactly WIDTH shift cycles.
    task automatic model_frame(input bit [2:0] a, input logic [WIDTH-1:0] d,
                               input bit o, input int nbits);
        ev_t e;
        e.addr = a;
        if (nbits == WIDTH) begin
            e.commit = 1'b1;
            mbank[a] = d;
            movf[a]  = o;
        end else begin
            e.commit = 1'b0;
            if (exp_errs < ERRMAX) exp_errs++;
        end
        e.errs = exp_errs;
        expq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit [2:0] a, input logic [WIDTH-1:0] d,
                              input bit o, input int nbits);
        model_frame(a, d, o, nbits);
        for (int i = 0; i < nbits; i++) begin
            sl_in     = 1'b1;
            serial_in = (i < WIDTH) ? d[WIDTH-1-i] : 1'($urandom);
            addr_in   = (i == 0) ? a : 3'($urandom);
            ovf_ch_in = (i == WIDTH-1) ? o : 1'($urandom);
            tick();
        end
        sl_in     = 1'b0;
        serial_in = 1'($urandom);
        addr_in   = 3'($urandom);
        ovf_ch_in = 1'($urandom);
        tick();
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_slot(input bit [2:0] a);
        rd_addr = a;
        tick();
        check($sformatf("rd_data[%0d]", a), rd_data, mbank[a]);
        check($sformatf("rd_ovf[%0d]", a), rd_ovf, movf[a]);
    endtask

    always @(negedge clk) begin
        if (!reset && (word_valid || frame_err)) begin
            checks++;
            if (word_valid && frame_err) begin
                failures++;
                $display("FAIL both_pulses: word_valid=1 frame_err=1 expected one");
            end else if (expq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: word_valid=%0b frame_err=%0b expected none",
                         word_valid, frame_err);
            end else begin
                ev_t e;
                e = expq.pop_front();
                if (word_valid != e.commit) begin
                    failures++;
                    $display("FAIL event_kind: word_valid=%0b expected %0b",
                             word_valid, e.commit);
                end else if (e.commit && word_addr != e.addr) begin
                    failures++;
                    $display("FAIL word_addr: got %0d expected %0d", word_addr, e.addr);
                end else if (int'(err_count) != e.errs) begin
                    failures++;
                    $display("FAIL err_count_evt: got %0d expected %0d", err_count, e.errs);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int n;
        logic [WIDTH-1:0] d;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Dirty some state, then reset in the middle of a frame
        send_frame(3'd3, 16'hCAFE, 1'b1, WIDTH);
        send_frame(3'd1, 16'h1234, 1'b0, 7);
        rd_addr = 3'd3;
        tick();
        tick();
        check("pre_reset_rd", rd_data, 16'hCAFE);
        for (int i = 0; i < 5; i++) begin
            sl_in = 1'b1;
            serial_in = 1'($urandom);
            addr_in = 3'd2;
            tick();
        end
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_ovf", rd_ovf, 0);
        check("rst_word_valid", word_valid, 0);
        check("rst_word_addr", word_addr, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_count", err_count, 0);
        sl_in = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        for (int a = 0; a < 8; a++) check_slot(3'(a));
        check("rst_err_count2", err_count, 0);

        send_frame(3'd5, 16'hA5C3, 1'b1, WIDTH);
        check_slot(3'd5);

        for (int a = 0; a < 8; a++)
            send_frame(3'(a), 16'(16'h1111 * (a + 1)), 1'b0, WIDTH);
        for (int a = 0; a < 8; a++) check_slot(3'(a));

        send_frame(3'd2, 16'hBEEF, 1'b0, WIDTH);
        send_frame(3'd2, 16'h5555, 1'b1, 10);
        tick();
        check("short_err_count", err_count, 1);
        check_slot(3'd2);

        send_frame(3'd4, 16'h9999, 1'b1, WIDTH + 1);
        check_slot(3'd4);
        for (int i = 0; i < 300; i++)
            send_frame(3'($urandom), 16'($urandom), 1'($urandom),
                       int'($urandom_range(1, WIDTH - 1)));
        tick();
        check("err_saturate", err_count, ERRMAX);

        send_frame(3'd6, 16'h0F0F, 1'b0, WIDTH);
        check_slot(3'd6);
        rd_addr = 3'd6;
        send_frame(3'd6, 16'h1234, 1'b1, WIDTH);
        check("bypass_same_cycle", rd_data, 16'h1234);
        check("bypass_ovf", rd_ovf, 1);
        tick();
        check("bypass_next_cycle", rd_data, 16'h1234);

        for (int i = 0; i < 60; i++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WIDTH + 3)) : WIDTH;
            d = 16'($urandom);
            rd_addr = 3'($urandom);
            send_frame(3'($urandom), d, 1'($urandom), n);
            repeat ($urandom_range(0, 2)) tick();
        end
        for (int a = 0; a < 8; a++) check_slot(3'(a));

        repeat (4) tick();
        check("queue_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chan_frame_rx.md
Name: chan_frame_rx

Overview:
- Receive-side deserializer for the channel-counter serial link. It consumes the serial data line, the shift/load strobe, the 3-bit word address and the per-word channel-overflow flag.
- It rebuilds each WIDTH-bit word into an 8-slot register bank, one slot per address.
- It flags malformed frames and offers a registered random-access read port, so the counter datapath can be checked or consumed on-chip or on an FPGA companion.

Parameters:
- WIDTH, 16, bits per serial word, shifted MSB first; legal range 2..32.
- ERRW, 8, width of the saturating frame-error counter.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- serial_in  input  1  serial data bit, valid on every clk edge where sl_in=1.
- sl_in  input  1  shift/load strobe; 1 = shift phase, 0 = load/idle.
- addr_in  input  3  word address {a2,a1,a0}; sampled on the first shift cycle of a frame.
- ovf_ch_in  input  1  channel-overflow flag; sampled on the last (WIDTH-th) shift cycle.
- rd_addr  input  3  bank read address.
- rd_data  output  WIDTH  registered bank word for rd_addr.
- rd_ovf  output  1  registered overflow bit for rd_addr.
- word_valid  output  1  one-cycle pulse when a frame commits.
- word_addr  output  3  slot written by the last commit; held until the next commit.
- frame_err  output  1  one-cycle pulse when a frame is discarded.
- err_count  output  ERRW  saturating count of discarded frames.

Behaviour:
- Reset (async, immediate):
  - FSM goes to IDLE; shift register, bit counter and overrun flag clear.
  - All bank words and overflow bits go to 0.
  - rd_data=0, rd_ovf=0, word_valid=0, word_addr=0, frame_err=0, err_count=0.
- FSM has two states: IDLE and SHIFT.
- IDLE, sl_in=1 sampled:
  - Latch addr_in into cur_addr.
  - Shift serial_in in as the MSB-first bit 1; cnt=1.
  - Go to SHIFT. When WIDTH=1 is not allowed, so the frame is never complete in IDLE.
- IDLE, sl_in=0: hold all state.
- SHIFT, sl_in=1, cnt<WIDTH:
  - shreg = {shreg[WIDTH-2:0], serial_in}; cnt++.
  - When cnt becomes WIDTH, capture ovf_ch_in into cur_ovf.
- SHIFT, sl_in=1, cnt==WIDTH:
  - Set the overrun flag.
  - Discard further bits; shreg and cnt are frozen.
- SHIFT, sl_in=0 (end of frame) → return to IDLE and do exactly one of:
  - cnt==WIDTH and no overrun → commit: bank[cur_addr]=shreg, ovfbank[cur_addr]=cur_ovf, word_addr=cur_addr, word_valid=1 for exactly that one cycle.
  - otherwise (short frame or overrun) → no bank write; frame_err=1 for one cycle; err_count++ unless already at all-ones (saturates, no wrap).
- Latency: word_valid/frame_err rise on the edge that samples the first sl_in=0 after the shift phase.
  - The minimum frame is WIDTH shift cycles plus 1 load cycle.
  - Back-to-back frames are legal: sl_in may return to 1 on the cycle after the load cycle.
- Read port:
  - rd_data/rd_ovf <= bank[rd_addr] every cycle, 1-cycle latency.
  - Write-through bypass: if a commit in the same cycle targets rd_addr, the new word and ovf bit are returned.
- addr_in and ovf_ch_in are ignored outside their sample cycles.
- Rewriting a slot overwrites it; there is no per-slot valid bit.
- Reset asserted mid-frame aborts the frame silently: no frame_err and no err_count increment.

Test Plan:
- Reset values: assert reset mid-frame (after 5 bits) → all outputs 0 immediately. Release and read all 8 slots → rd_data=0, rd_ovf=0, err_count=0.
- Single frame, WIDTH=16, addr_in=3'd5, bits 0xA5C3 MSB first, ovf_ch_in=1 on bit 16, then sl_in=0:
  - word_valid pulses exactly 1 cycle with word_addr=5.
  - Next cycle with rd_addr=5 → rd_data=0xA5C3, rd_ovf=1.
- All slots: 8 back-to-back frames, addr 0..7, data 0x1111*(addr+1) → 8 word_valid pulses. Readback of each slot matches with rd_ovf=0.
- Short frame: 10 bits then sl_in=0 at addr 2 holding 0xBEEF:
  - frame_err pulses once, no word_valid, err_count=1.
  - Slot 2 still reads 0xBEEF.
- Overrun: 17 shift cycles at addr 4 → frame_err, slot 4 unchanged. Repeat 300 short frames → err_count saturates at 255.
- Bypass: hold rd_addr=6 while committing 0x1234 to slot 6 (old value 0x0F0F) → rd_data=0x1234 on the cycle after word_valid, never the stale 0x0F0F.
